// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with a 2-entry skid buffer, registered o_ready
// and a synchronous flush that turns the head entry into a bubble.
module pipe_stage_skid_reg #(
  parameter int               CTRL_W        = 16,
  parameter int               DATA_W        = 128,
  parameter logic [CTRL_W-1:0] KILL_MASK    = {CTRL_W{1'b1}},
  parameter bit               FLUSH_KEEP_IN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              ready_reg, ready_next;
  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0] ctrl_killed;
  logic              in_fire, out_fire;

  // Bits selected by KILL_MASK are cleared on flush; the rest hold.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_kill
      assign ctrl_killed[gi] = KILL_MASK[gi] ? 1'b0 : main_ctrl_reg[gi];
    end
  endgenerate

  assign in_fire  = i_valid & ready_reg;
  assign out_fire = (state_reg != EMPTY) & i_ready;

  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    main_data_next = main_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    skid_data_next = skid_data_reg;
    if (i_flush) begin
      if (FLUSH_KEEP_IN && in_fire) begin
        main_ctrl_next = i_ctrl;
        main_data_next = i_data;
        state_next     = HALF;
      end else begin
        main_ctrl_next = ctrl_killed;
        state_next     = EMPTY;
      end
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_next = i_ctrl;
            main_data_next = i_data;
            state_next     = HALF;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_ctrl_next = i_ctrl;
            main_data_next = i_data;
          end else if (in_fire) begin
            skid_ctrl_next = i_ctrl;
            skid_data_next = i_data;
            state_next     = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // o_ready is low here, so only a drain can happen.
          if (out_fire) begin
            main_ctrl_next = skid_ctrl_reg;
            main_data_next = skid_data_reg;
            state_next     = HALF;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
    ready_next = (state_next != FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= EMPTY;
      ready_reg     <= 1'b1;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= ready_next;
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      skid_data_reg <= skid_data_next;
    end
  end

  assign o_ready     = ready_reg;
  assign o_valid     = (state_reg != EMPTY);
  assign o_ctrl      = main_ctrl_reg;
  assign o_data      = main_data_reg;
  assign o_occupancy = state_reg;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench: one stage with FLUSH_KEEP_IN=0 and one with FLUSH_KEEP_IN=1 share stimulus.
module tb_pipe_stage_skid_reg;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset, i_flush, i_valid, i_ready;
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data;
  logic              o_ready0, o_valid0, o_ready1, o_valid1;
  logic [CTRL_W-1:0] o_ctrl0, o_ctrl1;
  logic [DATA_W-1:0] o_data0, o_data1;
  logic [1:0]        o_occ0, o_occ1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .KILL_MASK(16'h00FF),
                        .FLUSH_KEEP_IN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready0),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(o_valid0), .i_ready(i_ready),
    .o_ctrl(o_ctrl0), .o_data(o_data0), .o_occupancy(o_occ0));

  pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .KILL_MASK(16'h00FF),
                        .FLUSH_KEEP_IN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready1),
    .i_ctrl(i_ctrl), .i_data(i_data), .o_valid(o_valid1), .i_ready(i_ready),
    .o_ctrl(o_ctrl1), .o_data(o_data1), .o_occupancy(o_occ1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
    i_valid = v;
    i_ctrl  = c;
    i_data  = {8{c}};
  endtask

  initial begin
    reset = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    drive(1'b1, 16'hFFFF);
    step(); step();
    $display("reset held two cycles");
    chk("rst_valid", o_valid0, 1'b0);
    chk("rst_ctrl", o_ctrl0, 16'h0);
    chk("rst_data", o_data0, 128'h0);
    chk("rst_occ", o_occ0, 2'd0);
    reset = 1'b1;
    drive(1'b0, 16'h0);
    step();
    $display("reset released");
    chk("rst_ready", o_ready0, 1'b1);
    chk("rst_valid_after", o_valid0, 1'b0);

    // Streaming with no backpressure
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k));
      step();
      $display("stream push ctrl=%0d", k);
      chk("stream_valid", o_valid0, 1'b1);
      chk("stream_ctrl", o_ctrl0, 16'(k));
      chk("stream_data", o_data0, {8{16'(k)}});
      chk("stream_occ", o_occ0, 2'd1);
      chk("stream_ready", o_ready0, 1'b1);
    end
    drive(1'b0, 16'h0);
    step();
    $display("stream drained");
    chk("stream_end_valid", o_valid0, 1'b0);
    chk("stream_end_ctrl", o_ctrl0, 16'd4);

    // Backpressure: A=5, B=6 fill the stage, C=7 waits upstream
    i_ready = 1'b0;
    drive(1'b1, 16'd5); step();
    $display("bp push A");
    chk("bp_a_occ", o_occ0, 2'd1);
    chk("bp_a_ctrl", o_ctrl0, 16'd5);
    drive(1'b1, 16'd6); step();
    $display("bp push B");
    chk("bp_b_occ", o_occ0, 2'd2);
    chk("bp_b_ready", o_ready0, 1'b0);
    chk("bp_b_ctrl", o_ctrl0, 16'd5);
    drive(1'b1, 16'd7); step();
    $display("bp C held");
    chk("bp_c_occ", o_occ0, 2'd2);
    chk("bp_c_ctrl", o_ctrl0, 16'd5);
    i_ready = 1'b1; step();
    $display("bp release deliver A");
    chk("bp_out_b", o_ctrl0, 16'd6);
    chk("bp_out_b_occ", o_occ0, 2'd1);
    chk("bp_out_b_ready", o_ready0, 1'b1);
    step();
    $display("bp deliver B accept C");
    chk("bp_out_c", o_ctrl0, 16'd7);
    chk("bp_out_c_data", o_data0, {8{16'd7}});
    chk("bp_out_c_valid", o_valid0, 1'b1);
    drive(1'b0, 16'h0); step();
    $display("bp deliver C");
    chk("bp_end_valid", o_valid0, 1'b0);

    // Flush with stage FULL
    i_ready = 1'b0;
    drive(1'b1, 16'hABCD); step();
    drive(1'b1, 16'h1234); step();
    $display("flush setup occ=%0d", o_occ0);
    chk("fl_setup_occ", o_occ0, 2'd2);
    drive(1'b0, 16'h0);
    i_flush = 1'b1; step();
    $display("flush full stage");
    chk("fl_valid", o_valid0, 1'b0);
    chk("fl_ctrl", o_ctrl0, 16'hAB00);
    chk("fl_data", o_data0, {8{16'hABCD}});
    chk("fl_occ", o_occ0, 2'd0);
    chk("fl_ready", o_ready0, 1'b1);
    chk("fl_keep_ctrl", o_ctrl1, 16'hAB00);
    i_flush = 1'b0; i_ready = 1'b1; step();
    $display("flush skid discarded");
    chk("fl_no_skid", o_valid0, 1'b0);
    chk("fl_no_skid_occ", o_occ0, 2'd0);

    // Flush with simultaneous input
    i_ready = 1'b0; i_flush = 1'b1;
    drive(1'b1, 16'd9); step();
    $display("flush with input ctrl=9");
    chk("fk0_valid", o_valid0, 1'b0);
    chk("fk0_ctrl", o_ctrl0, 16'hAB00);
    chk("fk1_valid", o_valid1, 1'b1);
    chk("fk1_ctrl", o_ctrl1, 16'd9);
    chk("fk1_occ", o_occ1, 2'd1);
    i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, 16'h0); step();
    $display("drain keep-in entry");
    chk("fk1_drained", o_valid1, 1'b0);

    // Reset mid-operation
    i_ready = 1'b0;
    drive(1'b1, 16'd21); step();
    drive(1'b1, 16'd22); step();
    chk("mr_full", o_occ0, 2'd2);
    i_ready = 1'b1; drive(1'b0, 16'h0); step();
    chk("mr_half_ctrl", o_ctrl0, 16'd22);
    i_ready = 1'b0; drive(1'b1, 16'd23); step();
    $display("mid-op stage full occ=%0d", o_occ0);
    chk("mr_refull", o_occ0, 2'd2);
    reset = 1'b0; i_ready = 1'b1; i_flush = 1'b1; step();
    $display("mid-op reset");
    chk("mr_valid", o_valid0, 1'b0);
    chk("mr_ctrl", o_ctrl0, 16'h0);
    chk("mr_data", o_data0, 128'h0);
    chk("mr_occ", o_occ0, 2'd0);
    chk("mr_ready", o_ready0, 1'b1);
    chk("mr_valid1", o_valid1, 1'b0);
    reset = 1'b1; i_flush = 1'b0; drive(1'b0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      $display("post-reset idle cycle %0d", k);
      chk("mr_idle_valid", o_valid0, 1'b0);
      chk("mr_idle_valid1", o_valid1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
